// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared constants, event type and helpers for the key matrix scanner.
package key_scan_pkg;

  localparam int unsigned NUM_COLS   = 6;
  localparam int unsigned NUM_ROWS   = 4;
  localparam int unsigned KEY_CODE_W = 5;
  localparam int unsigned NUM_KEYS   = NUM_COLS * NUM_ROWS;

  // Column drive for index 0; later columns are this value shifted right by the index.
  localparam logic [NUM_COLS-1:0] COL_FIRST = 6'b100000;

  typedef struct packed {
    logic                  press;
    logic [KEY_CODE_W-1:0] code;
  } key_event_t;

  typedef enum logic {
    EM_IDLE,
    EM_EMIT
  } emit_state_t;

  // Key index = col*4 + row, formed by concatenation since NUM_ROWS is 4.
  function automatic logic [KEY_CODE_W-1:0] key_index(input logic [2:0] col,
                                                      input logic [1:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: key event queue with valid/ack handshake and overflow pulse.
// Depth is 4 when KEY_SCAN_FIFO_EN is defined, otherwise a single holding register.
module key_event_fifo
  import key_scan_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  push_press,
  input  logic [KEY_CODE_W-1:0] push_code,
  input  logic                  ack,
  output logic                  valid,
  output logic                  head_press,
  output logic [KEY_CODE_W-1:0] head_code,
  output logic                  overflow
);

`ifdef KEY_SCAN_FIFO_EN
  localparam int unsigned DEPTH = 4;
`else
  localparam int unsigned DEPTH = 1;
`endif
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  key_event_t    mem [DEPTH];
  logic [CW-1:0] count;
  logic          do_pop;
  logic          do_push;
  logic [IW-1:0] wr_idx;

  // Handshake decode: a pop in the same cycle frees a slot for the incoming event.
  always_comb begin
    valid      = (count != '0);
    head_press = mem[0].press;
    head_code  = mem[0].code;
    do_pop     = valid & ack;
    do_push    = push & ((count != CW'(DEPTH)) | do_pop);
    wr_idx     = IW'(count - CW'(do_pop));
  end

  // Shift-register queue: head always in mem[0]; the write lands after the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[IW'(i)] <= '0;
    end else begin
      if (do_pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) mem[IW'(i)] <= mem[IW'(i + 1)];
      end
      if (do_push) mem[wr_idx] <= '{press: push_press, code: push_code};
      count    <= count + CW'(do_push) - CW'(do_pop);
      overflow <= push & ~do_push;
    end
  end

endmodule

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 6x4 key matrix scanner with per-key debounce integrators and an
// event queue. Queue depth selected by KEY_SCAN_FIFO_EN (defined: 4, else 1).
module key_matrix_scan
  import key_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DB_MAX   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_ROWS-1:0]   rows,
  output logic [NUM_COLS-1:0]   column,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_press,
  input  logic                  key_ack,
  output logic                  overflow,
  output logic                  any_key
);

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [2:0]  DB_TOP     = 3'(DB_MAX);
  localparam logic [2:0]  LAST_COL   = 3'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] rows_s1;
  logic [NUM_ROWS-1:0] rows_s2;
  logic [15:0]         dwell;
  logic [2:0]          col_idx;
  logic                tick;

  logic [2:0]          integ [NUM_KEYS];
  logic [NUM_KEYS-1:0] db_state;

  logic [2:0]          integ_cur [NUM_ROWS];
  logic [2:0]          integ_nxt [NUM_ROWS];
  logic [NUM_ROWS-1:0] st_cur;
  logic [NUM_ROWS-1:0] chg_nxt;
  logic [NUM_ROWS-1:0] press_nxt;

  logic [NUM_ROWS-1:0] pend_chg;
  logic [NUM_ROWS-1:0] pend_press;
  logic [2:0]          pend_col;

  emit_state_t         em_state;
  emit_state_t         em_state_nxt;
  logic [1:0]          emit_row;
  logic                push;
  key_event_t          push_ev;

  // Two-flop synchronizer for the asynchronous return lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_s1 <= '0;
      rows_s2 <= '0;
    end else begin
      rows_s1 <= rows;
      rows_s2 <= rows_s1;
    end
  end

  // Sample cycle is the terminal count of the dwell counter.
  always_comb begin
    tick   = (dwell == DWELL_LAST);
    column = COL_FIRST >> col_idx;
  end

  // Dwell counter and column index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      col_idx <= '0;
    end else if (tick) begin
      dwell   <= '0;
      col_idx <= (col_idx == LAST_COL) ? '0 : col_idx + 3'd1;
    end else begin
      dwell <= dwell + 16'd1;
    end
  end

  // Saturating integrator step and debounced-state change detection for the current column.
  always_comb begin
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      integ_cur[r] = integ[key_index(col_idx, 2'(r))];
      st_cur[r]    = db_state[key_index(col_idx, 2'(r))];
      if (rows_s2[r]) integ_nxt[r] = (integ_cur[r] == DB_TOP) ? integ_cur[r] : integ_cur[r] + 3'd1;
      else            integ_nxt[r] = (integ_cur[r] == 3'd0)   ? 3'd0        : integ_cur[r] - 3'd1;
      press_nxt[r] = ~st_cur[r] & (integ_nxt[r] == DB_TOP);
      chg_nxt[r]   = press_nxt[r] | (st_cur[r] & (integ_nxt[r] == 3'd0));
    end
  end

  // Key state update at the sample cycle; changes latched for emission over the next four cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) integ[5'(k)] <= '0;
      db_state   <= '0;
      pend_chg   <= '0;
      pend_press <= '0;
      pend_col   <= '0;
    end else if (tick) begin
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
        integ[key_index(col_idx, 2'(r))] <= integ_nxt[r];
        if (chg_nxt[r]) db_state[key_index(col_idx, 2'(r))] <= press_nxt[r];
      end
      pend_chg   <= chg_nxt;
      pend_press <= press_nxt;
      pend_col   <= col_idx;
    end
  end

  // Emission FSM state register and row slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_state <= EM_IDLE;
      emit_row <= '0;
    end else begin
      em_state <= em_state_nxt;
      if (tick)                     emit_row <= '0;
      else if (em_state == EM_EMIT) emit_row <= emit_row + 2'd1;
    end
  end

  // One row slot per clock; rows without a change still consume their slot.
  always_comb begin
    em_state_nxt = em_state;
    push         = 1'b0;
    push_ev      = '{press: pend_press[emit_row], code: key_index(pend_col, emit_row)};
    case (em_state)
      EM_IDLE: if (tick) em_state_nxt = EM_EMIT;
      EM_EMIT: begin
        push = pend_chg[emit_row];
        if (emit_row == 2'd3) em_state_nxt = EM_IDLE;
      end
      default: em_state_nxt = EM_IDLE;
    endcase
  end

  // any_key reflects debounced state only.
  always_comb begin
    any_key = |db_state;
  end

  key_event_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_press (push_ev.press),
    .push_code  (push_ev.code),
    .ack        (key_ack),
    .valid      (key_valid),
    .head_press (key_press),
    .head_code  (key_code),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench for key_matrix_scan (SCAN_DIV = 8, DB_MAX = 3), randomized rows/ack/reset
// against a cycle-level behavioural model. Honours KEY_SCAN_FIFO_EN for the queue depth.
module tb_key_matrix_scan;

  localparam int SD = 8;
  localparam int DB = 3;
`ifdef KEY_SCAN_FIFO_EN
  localparam int QDEPTH = 4;
`else
  localparam int QDEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rows;
  logic [5:0] column;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_press;
  logic       key_ack;
  logic       overflow;
  logic       any_key;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    bit press;
    int code;
  } ev_t;

  ev_t mq[$];
  int  integ[24];
  bit  st[24];
  bit  pend_v[4];
  ev_t pend_e[4];
  int  e;
  bit  m_ovf;
  int  ack_pct;

  key_matrix_scan #(.SCAN_DIV(SD), .DB_MAX(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rows      (rows),
    .column    (column),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_press (key_press),
    .key_ack   (key_ack),
    .overflow  (overflow),
    .any_key   (any_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t (cycle %0d)", tag, got, exp, $time, e);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < 24; k++) begin
      integ[k] = 0;
      st[k]    = 0;
    end
    for (int r = 0; r < 4; r++) pend_v[r] = 0;
    m_ovf = 0;
    e     = 0;
  endtask

  // Model of one clock edge; e is the number of edges since reset release.
  task automatic model_edge();
    bit pop, full;
    int col, k, r;
    pop   = (mq.size() > 0) && key_ack;
    full  = (mq.size() == QDEPTH);
    m_ovf = 0;
    if (pop) void'(mq.pop_front());
    if (e % SD >= 1 && e % SD <= 4) begin
      r = e % SD - 1;
      if (pend_v[r]) begin
        if (full && !pop) m_ovf = 1;
        else mq.push_back(pend_e[r]);
      end
    end
    if (e % SD == 0) begin
      col = ((e - 1) / SD) % 6;
      for (int rr = 0; rr < 4; rr++) begin
        k = col * 4 + rr;
        if (rows[rr]) begin
          if (integ[k] < DB) integ[k]++;
        end else begin
          if (integ[k] > 0) integ[k]--;
        end
        pend_v[rr] = 0;
        if (!st[k] && integ[k] == DB) begin
          st[k] = 1; pend_v[rr] = 1; pend_e[rr] = '{press: 1'b1, code: k};
        end else if (st[k] && integ[k] == 0) begin
          st[k] = 0; pend_v[rr] = 1; pend_e[rr] = '{press: 1'b0, code: k};
        end
      end
    end
  endtask

  task automatic compare();
    bit any;
    any = 0;
    for (int k = 0; k < 24; k++) any |= st[k];
    check("column", column, 32'd1 << (5 - (e / SD) % 6));
    check("key_valid", key_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("key_code", key_code, mq[0].code);
      check("key_press", key_press, mq[0].press);
    end
    check("overflow", overflow, m_ovf);
    check("any_key", any_key, any);
  endtask

  task automatic check_reset();
    check("rst_column", column, 32'h20);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_press", key_press, 0);
    check("rst_overflow", overflow, 0);
    check("rst_any_key", any_key, 0);
  endtask

  task automatic step(input bit rnd);
    if (rnd) begin
      if (e % SD == 2 && $urandom_range(0, 23) == 0) rows = 4'($urandom_range(0, 15));
      key_ack = ($urandom_range(0, 99) < ack_pct);
    end
    @(posedge clk);
    e++;
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset();
    @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n   = 1'b0;
    rows    = '0;
    key_ack = 1'b0;
    ack_pct = 100;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: full column rotation back to column 0 with no events.
    for (int i = 0; i < 7 * SD; i++) step(1'b0);

    // Randomized rows, ack duty and occasional reset during the emission window.
    for (int i = 0; i < 9000; i++) begin
      if (i % 400 == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    ack_pct = 0;
          2:       ack_pct = 40;
          default: ack_pct = 100;
        endcase
      end
      if (e % SD == 1 && e > SD && $urandom_range(0, 149) == 0) do_reset();
      step(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
